// File: rtl/booth_r8_ctrl.sv
// Radix-8 Booth sequencer: Load, per iteration Eval/[Add|Addc]/Shift, then Done; outputs registered (Moore).
// Latency 2..3 cycles per iteration plus Load and Done; no backpressure, Start is sampled only in IDLE.
module booth_r8_ctrl #(
    parameter int N    = 8,
    parameter int ITER = (N + 3) / 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] win_i,
    output logic [2:0] si_o,
    output logic [2:0] mult_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_ADDC  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    si_q, si_d;
    logic [2:0]    mult_q, mult_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // d = pos - 4*b3 with pos = 2*b2 + b1 + b0 in 0..4; b3 set and pos==4 folds to zero.
    logic [2:0] dig_pos;
    logic [2:0] dig_mag;
    logic       dig_neg;

    always_comb begin
        dig_pos = {1'b0, win_i[2], 1'b0} + {2'b00, win_i[1]} + {2'b00, win_i[0]};
        dig_neg = win_i[3] && (dig_pos != 3'd4);
        dig_mag = win_i[3] ? (3'd4 - dig_pos) : dig_pos;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        si_d    = OP_NOP;
        mult_d  = 3'd0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = S_LOAD;
                    si_d    = OP_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (dig_mag != 3'd0) begin
                    state_d = S_ADD;
                    si_d    = dig_neg ? OP_ADDC : OP_ADD;
                    mult_d  = dig_mag;
                end else begin
                    state_d = S_SHIFT;
                    si_d    = OP_SHIFT;
                end
            end
            S_ADD: begin
                state_d = S_SHIFT;
                si_d    = OP_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q < CW'(ITER - 1)) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            si_q    <= OP_NOP;
            mult_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            si_q    <= si_d;
            mult_q  <= mult_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign si_o   = si_q;
    assign mult_o = mult_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_booth_r8_ctrl.sv
// Bench for booth_r8_ctrl: a trace model built from Booth digits and window arithmetic is compared every cycle.
module tb_booth_r8_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] win_i = 4'd0;
    logic [2:0] si_o;
    logic [2:0] mult_o;
    logic       busy_o;
    logic       done_o;

    booth_r8_ctrl #(.N(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .win_i  (win_i),
        .si_o   (si_o),
        .mult_o (mult_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected trace, one entry per cycle; e_win is what the datapath presents during that cycle.
    int         e_si[32];
    int         e_mult[32];
    int         e_busy[32];
    int         e_done[32];
    logic [3:0] e_win[32];
    int         n_tr;

    // Hand-derived Si/Mult seen in the cycle after EVAL for each window value.
    int lit_si[16] = '{4, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 4};
    int lit_m[16]  = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int digit(input logic [3:0] w);
        return -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    endfunction

    task automatic push(input int si, input int m, input int b, input int d, input logic [3:0] w);
        e_si[n_tr]   = si;
        e_mult[n_tr] = m;
        e_busy[n_tr] = b;
        e_done[n_tr] = d;
        e_win[n_tr]  = w;
        n_tr++;
    endtask

    // smode: 0 single Start pulse, 1 extra pulses in cycles 3 and 6, 2 Start held high throughout.
    task automatic run(input logic [7:0] m, input bit use_tab, input logic [3:0] t0,
                       input logic [3:0] t1, input logic [3:0] t2, input int smode,
                       input int rst_at, output int done_cyc, output int obs_si3,
                       output int obs_m3);
        logic [3:0] wt[3];
        int v, d, dcount;
        v = int'($signed(m)) * 2;
        for (int k = 0; k < 3; k++) wt[k] = 4'(v >>> (3 * k));
        if (use_tab) begin
            wt[0] = t0;
            wt[1] = t1;
            wt[2] = t2;
        end
        n_tr = 0;
        push(0, 0, 0, 0, 4'($urandom));
        push(3, 0, 1, 0, 4'($urandom));
        for (int k = 0; k < 3; k++) begin
            push(0, 0, 1, 0, wt[k]);
            d = digit(wt[k]);
            if (d > 0) push(1, d, 1, 0, 4'($urandom));
            else if (d < 0) push(2, -d, 1, 0, 4'($urandom));
            push(4, 0, 1, 0, 4'($urandom));
        end
        push(0, 0, 1, 1, 4'($urandom));
        push(0, 0, 0, 0, 4'($urandom));
        if (smode == 2) push(3, 0, 1, 0, 4'($urandom));

        dcount   = 0;
        done_cyc = -1;
        obs_si3  = -1;
        obs_m3   = -1;
        for (int c = 0; c < n_tr; c++) begin
            chk("si", 32'(si_o), 32'(e_si[c]));
            chk("mult", 32'(mult_o), 32'(e_mult[c]));
            chk("busy", 32'(busy_o), 32'(e_busy[c]));
            chk("done", 32'(done_o), 32'(e_done[c]));
            if (done_o === 1'b1) begin
                dcount++;
                done_cyc = c;
            end
            if (c == 3) begin
                obs_si3 = int'(si_o);
                obs_m3  = int'(mult_o);
            end
            if (c == rst_at) begin
                start_i = 1'b0;
                rst_n   = 1'b0;
                #1;
                chk("rst_si", 32'(si_o), 32'd0);
                chk("rst_mult", 32'(mult_o), 32'd0);
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_done", 32'(done_o), 32'd0);
                #2;
                rst_n = 1'b1;
                return;
            end
            start_i = (smode == 2) || (c == 0) || (smode == 1 && (c == 3 || c == 6));
            win_i   = e_win[c];
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        chk("done_count", 32'(dcount), 32'd1);
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int dc, o_si, o_m;

    initial begin
        #1;
        chk("reset_si", 32'(si_o), 32'd0);
        chk("reset_mult", 32'(mult_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_si", 32'(si_o), 32'd0);
            chk("idle_mult", 32'(mult_o), 32'd0);
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_done", 32'(done_o), 32'd0);
        end

        run(8'h1E, 1'b0, 4'd0, 4'd0, 4'd0, 0, -1, dc, o_si, o_m);
        chk("x1E_done_cycle", 32'(dc), 32'd10);
        chk("x1E_first_op", 32'(o_si), 32'd2);
        chk("x1E_first_mult", 32'(o_m), 32'd2);

        run(8'hFF, 1'b0, 4'd0, 4'd0, 4'd0, 0, -1, dc, o_si, o_m);
        chk("xFF_done_cycle", 32'(dc), 32'd9);
        chk("xFF_first_op", 32'(o_si), 32'd2);
        chk("xFF_first_mult", 32'(o_m), 32'd1);

        for (int w = 0; w < 16; w++) begin
            run(8'h00, 1'b1, 4'(w), 4'($urandom), 4'($urandom), 0, -1, dc, o_si, o_m);
            chk("digit_op", 32'(o_si), 32'(lit_si[w]));
            chk("digit_mult", 32'(o_m), 32'(lit_m[w]));
        end

        run(8'h1E, 1'b0, 4'd0, 4'd0, 4'd0, 1, -1, dc, o_si, o_m);
        chk("busy_start_done_cycle", 32'(dc), 32'd10);

        run(8'h5A, 1'b0, 4'd0, 4'd0, 4'd0, 2, -1, dc, o_si, o_m);
        do_reset();

        run(8'h1E, 1'b0, 4'd0, 4'd0, 4'd0, 0, 3, dc, o_si, o_m);
        run(8'h1E, 1'b0, 4'd0, 4'd0, 4'd0, 0, -1, dc, o_si, o_m);
        chk("post_reset_done_cycle", 32'(dc), 32'd10);

        for (int i = 0; i < 40; i++) begin
            run(8'($urandom), 1'b0, 4'd0, 4'd0, 4'd0, int'($urandom_range(0, 1)), -1,
                dc, o_si, o_m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
